// File: rtl/display_scheduler.sv
// display_scheduler: round-robin picks one of three requesters, latches its byte for the hex display
// and holds it for at least DWELL cycles before the next arbitration.
module display_scheduler #(
  parameter int unsigned DWELL = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [2:0] gnt,
  output logic [7:0] disp_value,
  output logic [1:0] disp_src,
  output logic       disp_valid,
  output logic       busy
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [31:0] RELOAD = (DWELL == 0) ? 32'd0 : 32'(DWELL - 1);
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  last_q, last_d, src_q, src_d, first, second, win;
  logic [7:0]  val_q, val_d;
  logic        valid_q, valid_d;
  logic [2:0]  gnt_q, gnt_d;
  always_comb begin
    first   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    second  = (first == 2'd2) ? 2'd0 : first + 2'd1;
    win     = req[first] ? first : req[second] ? second : last_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    src_d   = src_q;
    val_d   = val_q;
    valid_d = valid_q;
    gnt_d   = 3'b000;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = HOLD;
        cnt_d   = RELOAD;
        last_d  = win;
        src_d   = win;
        valid_d = 1'b1;
        gnt_d   = 3'b001 << win;
        val_d   = (win == 2'd0) ? data0 : (win == 2'd1) ? data1 : data2;
      end
    end else if (cnt_q == 32'd0) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      last_q  <= 2'd2;
      src_q   <= 2'b11;
      val_q   <= 8'h00;
      valid_q <= 1'b0;
      gnt_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end
  assign gnt        = gnt_q;
  assign disp_value = val_q;
  assign disp_src   = src_q;
  assign disp_valid = valid_q;
  assign busy       = (state_q == HOLD);
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: randomized and directed checks of display_scheduler (DWELL=4 and DWELL=0)
// against a grant/hold-length model.
module tb_display_scheduler;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req, req_z;
  logic [7:0] d [3];
  logic [2:0] gnt, gnt_z;
  logic [7:0] disp_value, disp_value_z;
  logic [1:0] disp_src, disp_src_z;
  logic       disp_valid, disp_valid_z, busy, busy_z;
  int checks = 0, failures = 0;
  int m_last, m_hold;
  logic [2:0] m_gnt;
  logic [7:0] m_val;
  logic [1:0] m_src;
  logic       m_valid;

  display_scheduler #(.DWELL(D)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(d[0]), .data1(d[1]), .data2(d[2]),
    .gnt(gnt), .disp_value(disp_value), .disp_src(disp_src), .disp_valid(disp_valid), .busy(busy));
  display_scheduler #(.DWELL(0)) dut_z (
    .clk(clk), .reset(reset), .req(req_z), .data0(d[0]), .data1(d[1]), .data2(d[2]),
    .gnt(gnt_z), .disp_value(disp_value_z), .disp_src(disp_src_z), .disp_valid(disp_valid_z), .busy(busy_z));

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {gnt, disp_value, disp_src, disp_valid, busy};
  endfunction
  function automatic logic [14:0] expv();
    return {m_gnt, m_val, m_src, m_valid, m_hold > 0};
  endfunction

  task automatic m_reset();
    m_last = 2; m_hold = 0; m_gnt = 3'b000; m_val = 8'h00; m_src = 2'b11; m_valid = 1'b0;
  endtask

  // A grant occupies the display for max(DWELL,1) cycles; one idle edge follows before re-arbitration.
  task automatic tick();
    int w;
    bit found;
    @(posedge clk);
    m_gnt = 3'b000;
    if (m_hold > 0) m_hold--;
    else if (req != 3'b000) begin
      found = 0;
      w = 0;
      for (int k = 1; k <= 3; k++)
        if (!found && req[(m_last + k) % 3]) begin
          w = (m_last + k) % 3;
          found = 1;
        end
      m_last = w; m_gnt = 3'b001 << w; m_val = d[w]; m_src = 2'(w); m_valid = 1'b1;
      m_hold = (D == 0) ? 1 : D;
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 3'b000; req_z = 3'b000;
    d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00;
    m_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 15'({3'b000, 8'h00, 2'b11, 1'b0, 1'b0})) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", obs(), 15'({3'b000, 8'h00, 2'b11, 1'b0, 1'b0}));
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin failures++; $display("FAIL idle_after_reset[%0d] got=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  task automatic test_single();
    apply_reset();
    d[0] = 8'h3C; req = 3'b001;
    tick();
    checks++;
    if ({gnt, disp_value, disp_src, busy} !== {3'b001, 8'h3C, 2'd0, 1'b1}) begin
      failures++; $display("FAIL single_grant got=%h/%h/%h/%b exp=001/3c/0/1", gnt, disp_value, disp_src, busy);
    end
    req = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin failures++; $display("FAIL single_hold[%0d] got=%h exp=%h", i, obs(), expv()); end
    end
    checks++;
    if ({busy, disp_valid, disp_value} !== {1'b0, 1'b1, 8'h3C}) begin
      failures++; $display("FAIL single_retained got=%b/%b/%h exp=0/1/3c", busy, disp_valid, disp_value);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] gq[$];
    logic [7:0] vq[$];
    logic [2:0] eg [4];
    logic [7:0] ev [4];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    ev = '{8'h11, 8'h22, 8'h33, 8'h11};
    apply_reset();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; req = 3'b111;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin failures++; $display("FAIL rr_cycle[%0d] got=%h exp=%h", i, obs(), expv()); end
      if (gnt != 3'b000) begin
        gq.push_back(gnt);
        vq.push_back(disp_value);
        checks++;
        if (i % (D + 1) != 0) begin failures++; $display("FAIL rr_spacing got=%0d exp=0", i % (D + 1)); end
      end
    end
    checks++;
    if (gq.size() != 4) begin
      failures++; $display("FAIL rr_count got=%0d exp=4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({gq[i], vq[i]} !== {eg[i], ev[i]}) begin
          failures++; $display("FAIL rr_seq[%0d] got=%b/%h exp=%b/%h", i, gq[i], vq[i], eg[i], ev[i]);
        end
      end
    end
    req = 3'b000;
    repeat (D + 1) tick();
  endtask

  task automatic test_hold_ignores_inputs();
    apply_reset();
    repeat (2) tick();
    d[0] = 8'h77; d[1] = 8'hA5; req = 3'b010;
    tick();
    d[1] = 8'h5A; req = 3'b001;
    for (int i = 0; i < D; i++) begin
      checks++;
      if (disp_value !== 8'hA5) begin failures++; $display("FAIL hold_value[%0d] got=%h exp=a5", i, disp_value); end
      tick();
    end
    tick();
    checks++;
    if ({gnt, disp_value, disp_src} !== {3'b001, 8'h77, 2'd0}) begin
      failures++; $display("FAIL after_hold got=%b/%h/%0d exp=001/77/0", gnt, disp_value, disp_src);
    end
    checks++;
    if (obs() !== expv()) begin failures++; $display("FAIL after_hold_model got=%h exp=%h", obs(), expv()); end
    req = 3'b000;
    repeat (D + 1) tick();
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    d[0] = 8'h44; req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    #2 reset = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({gnt, disp_value, disp_src, disp_valid, busy} !== {3'b000, 8'h00, 2'b11, 1'b0, 1'b0}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs(), expv());
    end
    req = 3'b110; d[1] = 8'hB1; d[2] = 8'hC2;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL early_grant got=%b exp=000", gnt); end
    tick();
    checks++;
    if ({gnt, disp_value} !== {3'b010, 8'hB1}) begin
      failures++; $display("FAIL post_reset_grant got=%b/%h exp=010/b1", gnt, disp_value);
    end
    req = 3'b000;
    repeat (D + 1) tick();
  endtask

  task automatic test_random();
    int waitc [3];
    apply_reset();
    req = 3'b000;
    waitc = '{0, 0, 0};
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i] && m_gnt[i]) begin
          req[i] = 1'b0; d[i] = 8'($urandom);
        end else if (!req[i] && $urandom_range(3) == 0) begin
          d[i] = 8'($urandom); req[i] = 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) if (req[i]) waitc[i]++;
      tick();
      checks++;
      if (obs() !== expv()) begin failures++; $display("FAIL random[%0d] got=%h exp=%h", n, obs(), expv()); end
      for (int i = 0; i < 3; i++)
        if (gnt[i]) begin
          checks++;
          if (waitc[i] > 3 * (D + 1) + 1) begin failures++; $display("FAIL starvation[%0d] got=%0d exp<=%0d", i, waitc[i], 3 * (D + 1) + 1); end
          waitc[i] = 0;
        end
    end
    req = 3'b000;
    repeat (D + 1) tick();
  endtask

  task automatic test_dwell_zero();
    apply_reset();
    d[0] = 8'h5E; req = 3'b000; req_z = 3'b001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({gnt_z, busy_z, disp_value_z, disp_valid_z} !== {(i % 2 == 0) ? 3'b001 : 3'b000, i % 2 == 0, 8'h5E, 1'b1}) begin
        failures++; $display("FAIL dwell0[%0d] got=%b/%b/%h/%b exp=%b/%b/5e/1", i, gnt_z, busy_z, disp_value_z, disp_valid_z,
                             (i % 2 == 0) ? 3'b001 : 3'b000, i % 2 == 0);
      end
    end
    req_z = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_ignores_inputs();
    test_reset_mid_hold();
    test_random();
    test_dwell_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL, default 25000000, minimum number of cycles a granted value stays on the display; DWELL=0 SHALL behave as DWELL=1.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 req  input  3  per-requester display request; bit i belongs to requester i.
REQ-005 data0, data1, data2  input  8 each  value requester i wants shown; must be stable while req[i]=1.
REQ-006 gnt  output  3  one-hot grant; one-cycle pulse to the requester whose data was latched.
REQ-007 disp_value  output  8  value to feed the two-digit hex display driver's binary_value input.
REQ-008 disp_src  output  2  index of the requester that owns disp_value; 2'b11 = none since reset.
REQ-009 disp_valid  output  1  high once any value has been latched since reset.
REQ-010 busy  output  1  high while in HOLD (dwell in progress).

Function
REQ-011 Two states SHALL exist: IDLE and HOLD; all outputs SHALL be registered.
REQ-012 IDLE with req=000: state, disp_value, disp_src, disp_valid unchanged; gnt=000.
REQ-013 IDLE with any req bit set at a rising edge: winner chosen by round-robin; at that edge disp_value <= data_winner, disp_src <= winner, disp_valid <= 1, gnt <= onehot(winner), counter <= DWELL-1, last <= winner, state <= HOLD.
REQ-014 Round-robin: search order starts at (last+1) mod 3 and wraps; last SHALL reset to 2 so requester 0 has top priority after reset.
REQ-015 gnt SHALL be high for exactly the first HOLD cycle and 000 in every other cycle.
REQ-016 HOLD: req and data inputs ignored; counter decrements by 1 per cycle; at the edge where counter=0, state <= IDLE.
REQ-017 Latency: req seen at edge N -> gnt and new disp_value visible after edge N; earliest next grant at edge N+DWELL+1.
REQ-018 Requester SHALL deassert req (or change data) only after observing gnt; a req still high after its grant is treated as a new request at the next IDLE edge.
REQ-019 Simultaneous requests: exactly one grant per arbitration; losers keep req high and win in later rounds, no starvation (any persistent requester served within 3 rounds).
REQ-020 After HOLD ends with no pending req, the last value SHALL remain displayed indefinitely (busy=0, disp_valid=1).
REQ-021 Counter SHALL be 32 bits; no wrap-around is possible since it is reloaded only in IDLE and stops at 0.
REQ-022 Data change on a requester during HOLD SHALL NOT affect disp_value.

Reset
REQ-023 reset=0 SHALL immediately force: state IDLE, gnt=000, disp_value=8'h00, disp_src=2'b11, disp_valid=0, busy=0, counter=0, last=2.
REQ-024 Reset asserted mid-HOLD SHALL abort the dwell; after release, arbitration restarts from requester 0 with no grant issued before the first rising edge following release.

Verification (DWELL=4)
REQ-025 Reset release, req=000 for 10 cycles -> disp_value=00, disp_src=11, disp_valid=0, gnt=000 throughout.
REQ-026 req=001, data0=8'h3C held until gnt -> gnt=001 for one cycle, disp_value=3C, disp_src=0, busy=1 for 4 cycles, then busy=0 with 3C retained.
REQ-027 req=111 held, data0=11, data1=22, data2=33 -> grants 001,010,100,001 at 5-cycle spacing; disp_value 11,22,33,11.
REQ-028 Grant requester 1 with 8'hA5; during HOLD change data1 to 5A and raise req0 -> disp_value stays A5 until dwell ends, then requester 0 granted (priority after 1 is 2, then 0; req2 low).
REQ-029 Reset pulse in 2nd HOLD cycle -> outputs at reset values at once; after release with req=110, first grant goes to requester 1.
REQ-030 DWELL=0 build, req=001 held -> grants 001 every 2 cycles (one HOLD cycle between arbitrations).
